// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit state encoding and default frame geometry.
package uart_pkg;

   localparam int unsigned DATA_BITS_DEF  = 8;
   localparam int unsigned OVERSAMPLE_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both stages reset to RESET_VAL.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver timed by a 16x oversample tick; holds each byte under a valid/ack handshake.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   uart_state_e          r_state,       w_state_nxt;
   logic [TW-1:0]        r_tick_cnt,    w_tick_cnt_nxt;
   logic [BW-1:0]        r_bit_idx,     w_bit_idx_nxt;
   logic [DATA_BITS-1:0] r_shift,       w_shift_nxt;
   logic [DATA_BITS-1:0] r_data,        w_data_nxt;
   logic                 r_valid,       w_valid_nxt;
   logic                 r_frame_err,   w_frame_err_nxt;
   logic                 r_overrun_err, w_overrun_err_nxt;
   logic                 w_rx_s;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (rx),
      .o_sync  (w_rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_tick_cnt    <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_tick_cnt    <= w_tick_cnt_nxt;
         r_bit_idx     <= w_bit_idx_nxt;
         r_shift       <= w_shift_nxt;
         r_data        <= w_data_nxt;
         r_valid       <= w_valid_nxt;
         r_frame_err   <= w_frame_err_nxt;
         r_overrun_err <= w_overrun_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_tick_cnt_nxt    = r_tick_cnt;
      w_bit_idx_nxt     = r_bit_idx;
      w_shift_nxt       = r_shift;
      w_data_nxt        = r_data;
      w_valid_nxt       = r_valid & ~rx_ack;
      w_frame_err_nxt   = 1'b0;
      w_overrun_err_nxt = 1'b0;

      case (r_state)
         IDLE: begin
            if (tick && !w_rx_s) begin
               w_state_nxt    = START;
               w_tick_cnt_nxt = '0;
            end
         end
         START: begin
            if (tick) begin
               if (r_tick_cnt == MID_TICK) begin
                  // a start bit that is high again at mid-bit is treated as line noise
                  w_state_nxt    = w_rx_s ? IDLE : DATA;
                  w_tick_cnt_nxt = '0;
                  w_bit_idx_nxt  = '0;
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (r_tick_cnt == LAST_TICK) begin
                  w_shift_nxt    = {w_rx_s, r_shift[DATA_BITS-1:1]};
                  w_bit_idx_nxt  = r_bit_idx + 1'b1;
                  w_tick_cnt_nxt = '0;
                  if (r_bit_idx == LAST_BIT) begin
                     w_state_nxt = STOP;
                  end
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (r_tick_cnt == LAST_TICK) begin
                  w_tick_cnt_nxt = '0;
                  if (w_rx_s) begin
                     // a new byte beats a simultaneous ack and overwrites an unread one
                     w_data_nxt        = r_shift;
                     w_valid_nxt       = 1'b1;
                     w_overrun_err_nxt = r_valid & ~rx_ack;
                     w_state_nxt       = IDLE;
                  end else begin
                     w_frame_err_nxt = 1'b1;
                     w_state_nxt     = WAIT_HIGH;
                  end
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (tick && w_rx_s) begin
               w_state_nxt    = IDLE;
               w_tick_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_tick_cnt_nxt = '0;
         end
      endcase
   end

   assign rx_data     = r_data;
   assign rx_valid    = r_valid;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-indexed frame model checked against the DUT every cycle.
module tb_uart_rx;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       tick   = 1'b0;
   logic       rx     = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ack      (rx_ack),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model time is counted in ticks; a frame whose line drops while tcount==s
   // is detected on tick s, its stop bit is sampled on tick s+152.
   int         tcount    = 0;
   int         last_rst  = 0;
   int         cur_start = 0;
   int         cur_end   = 0;
   int         ev_tick   = -1;
   int         ev_kind   = 0;   // 0 none, 1 good byte, 2 framing error
   logic [7:0] ev_data   = '0;
   logic       m_valid   = 1'b0;
   logic       m_fe      = 1'b0;
   logic       m_ov      = 1'b0;
   logic [7:0] m_data    = '0;
   logic       exp_busy;

   bit chk_en    = 1'b0;
   bit ack_mode  = 1'b0;
   int ack_req   = 0;
   int ack_seen  = 0;
   int fe_cnt    = 0;
   int ov_cnt    = 0;
   int tick_ph   = 0;

   initial forever #10 clk = ~clk;

   initial forever begin
      @(negedge clk);
      tick    = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % 4;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // reference model of the byte handshake, advanced on every rising edge
   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_fe    = 1'b0;
         m_ov    = 1'b0;
         if (tick) tcount++;
         last_rst = tcount;
      end else begin
         m_fe = 1'b0;
         m_ov = 1'b0;
         if (tick && tcount == ev_tick && ev_kind != 0 && cur_start >= last_rst) begin
            if (ev_kind == 1) begin
               m_ov    = m_valid && !rx_ack;
               m_valid = 1'b1;
               m_data  = ev_data;
            end else begin
               m_fe = 1'b1;
               if (rx_ack) m_valid = 1'b0;
            end
         end else if (rx_ack) begin
            m_valid = 1'b0;
         end
         if (tick) tcount++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (frame_err === 1'b1)   fe_cnt++;
      if (overrun_err === 1'b1) ov_cnt++;
      if (chk_en) begin
         exp_busy = (tcount > cur_start) && (tcount <= cur_end) && (cur_start >= last_rst);
         check("outputs{data,valid,ferr,ovr,busy}",
               32'({rx_data, rx_valid, frame_err, overrun_err, busy}),
               32'({m_data, m_valid, m_fe, m_ov, exp_busy}));
      end
   end

   initial forever begin
      @(negedge clk);
      if (ack_mode) rx_ack = ($urandom_range(0, 11) == 0);
      else if (ack_seen != ack_req) begin
         rx_ack = 1'b1;
         ack_seen++;
      end else rx_ack = 1'b0;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ticks(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk);
         while (!tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      wait_ticks(16);
   endtask

   task automatic pulse_ack();
      ack_req++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned low_extra);
      int s;
      wait_ticks(1);
      s         = tcount;
      cur_start = s;
      ev_tick   = s + 152;
      ev_kind   = stop ? 1 : 2;
      ev_data   = d;
      cur_end   = stop ? s + 152 : (1 << 30);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      if (!stop) begin
         rx = 1'b0;
         wait_ticks(low_extra);
         if (low_extra >= 4) check("wait_high_busy", 32'(busy), 32'(1));
         cur_end = tcount;
         rx      = 1'b1;
      end
   endtask

   initial begin
      int fe0;
      int ov0;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      check("reset_valid", 32'(rx_valid), 32'(0));
      check("reset_data", 32'(rx_data), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_ferr", 32'(frame_err), 32'(0));
      check("reset_ovr", 32'(overrun_err), 32'(0));

      send_frame(8'hA5, 1'b1, 0);
      check("a5_data", 32'(rx_data), 32'h0000_00A5);
      check("a5_valid", 32'(rx_valid), 32'(1));
      check("a5_no_ferr", 32'(fe_cnt), 32'(0));
      pulse_ack();
      check("ack_clears_valid", 32'(rx_valid), 32'(0));

      send_frame(8'h3C, 1'b1, 0);
      check("3c_data", 32'(rx_data), 32'h0000_003C);
      pulse_ack();
      send_frame(8'hC3, 1'b1, 0);
      check("c3_data", 32'(rx_data), 32'h0000_00C3);
      check("c3_valid", 32'(rx_valid), 32'(1));
      check("b2b_no_overrun", 32'(ov_cnt), 32'(0));
      pulse_ack();

      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      check("overrun_once", 32'(ov_cnt), 32'(1));
      check("overrun_data", 32'(rx_data), 32'h0000_0022);
      check("overrun_valid", 32'(rx_valid), 32'(1));
      pulse_ack();

      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, 40);
      check("ferr_once", 32'(fe_cnt), 32'(fe0 + 1));
      check("ferr_no_valid", 32'(rx_valid), 32'(0));
      wait_ticks(4);
      check("idle_after_break", 32'(busy), 32'(0));

      fe0 = fe_cnt;
      ov0 = ov_cnt;
      wait_ticks(1);
      cur_start = tcount;
      cur_end   = tcount + 8;
      ev_kind   = 0;
      rx = 1'b0;
      wait_ticks(3);
      rx = 1'b1;
      wait_ticks(20);
      check("glitch_busy", 32'(busy), 32'(0));
      check("glitch_valid", 32'(rx_valid), 32'(0));
      check("glitch_no_err", 32'(fe_cnt + ov_cnt), 32'(fe0 + ov0));

      send_frame(8'h5A, 1'b1, 0);
      wait_ticks(1);
      cur_start = tcount;
      cur_end   = tcount + 152;
      ev_tick   = tcount + 152;
      ev_kind   = 1;
      ev_data   = 8'hFF;
      drive_bit(1'b0);
      repeat (4) drive_bit(1'b1);
      rx = 1'b1;
      wait_ticks(5);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_valid", 32'(rx_valid), 32'(0));
      check("midrst_data", 32'(rx_data), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      wait_ticks(10);
      send_frame(8'h81, 1'b1, 0);
      check("after_rst_data", 32'(rx_data), 32'h0000_0081);
      check("after_rst_valid", 32'(rx_valid), 32'(1));
      pulse_ack();

      ack_mode = 1'b1;
      for (int f = 0; f < 40; f++) begin
         send_frame(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(1, 24));
         wait_ticks($urandom_range(1, 8));
      end
      ack_mode = 1'b0;
      wait_ticks(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive end of the UART: de-serialises 8N1 frames from the `rx` line into bytes.
- Timed entirely by the 16x oversample `tick` from the existing baud generator, which runs off the 50 MHz system clock.
- Holds each received byte for the host under a valid/ack handshake.
- Flags framing and overrun errors.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- OVERSAMPLE, 16, `tick` pulses per bit period; must be even and ≥ 4.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk pulse, OVERSAMPLE per bit period, from the baud generator.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last good byte received.
- rx_valid  output  1  high while rx_data holds an unacknowledged byte.
- rx_ack  input  1  host consumes rx_data; clears rx_valid next cycle.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- overrun_err  output  1  one-clk pulse when a new byte lands while rx_valid is still set.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state changes on the clk rising edge.
- Synchroniser: `rx` passes through 2 flops to give rx_s. Both flops reset to 1. All sampling uses rx_s.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0, state=IDLE, tick_cnt=0, bit_idx=0, shift register=0.
- tick_cnt: width clog2(OVERSAMPLE). Advances only on cycles with tick=1. Cleared on every state entry.
- bit_idx: width clog2(DATA_BITS+1).
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on tick with rx_s=0, go to START (tick_cnt=0).
  - START: on tick, increment tick_cnt. On the tick where tick_cnt==OVERSAMPLE/2-1 (mid-bit), sample rx_s:
    - 0: go to DATA, tick_cnt=0, bit_idx=0.
    - 1: glitch; return to IDLE with no flag.
  - DATA: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s.
    - Shift it in at the MSB (right shift), so the first bit ends up at bit 0.
    - bit_idx++ and tick_cnt wraps to 0.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s:
    - 1: latch the shift register into rx_data, set rx_valid. If rx_valid was already 1 and rx_ack=0 this cycle, also pulse overrun_err (new byte overwrites the old). Go to IDLE.
    - 0: pulse frame_err, leave rx_data/rx_valid unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rx_s=1, then go to IDLE. This stops a break condition from re-triggering frames back to back.
- Latency: rx_valid rises the clk cycle after the tick that samples the stop bit.
- Handshake:
  - rx_ack with rx_valid=1: rx_valid=0 next cycle.
  - rx_ack with rx_valid=0: ignored.
  - rx_ack in the same cycle as a new byte latch: the new byte wins, rx_valid stays 1, no overrun.
- rx_data is stable whenever rx_valid=1, except on overrun overwrite.
- rst mid-frame: everything returns to reset values within 1 cycle and the partial byte is discarded. If `rx` is low when rst releases, a frame is detected only on the next tick with rx_s=0; the bench must present idle high.
- tick is ignored in cycles where rst=1.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH), shared with the planned uart_tx.
  - constants DATA_BITS_DEF=8, OVERSAMPLE_DEF=16.
- One natural sub-module: uart_sync2 (2-flop synchroniser, reset value 1), reusable for other async inputs.

Test Plan:
- Bench setup: 50 MHz clk, tick every 4 clks, so one bit = 64 clks.
- Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> rx_data=0xA5, rx_valid=1 one cycle after the stop-bit tick, frame_err=0.
- 0x3C then 0xC3 back to back with rx_ack pulsed between them -> two valids, data 0x3C then 0xC3, overrun_err never asserted.
- 0x11 then 0x22 with no ack -> overrun_err pulses once, rx_data=0x22, rx_valid stays 1.
- Frame 0x55 with stop bit driven 0 -> frame_err pulses once, rx_valid stays 0, FSM holds in WAIT_HIGH until `rx` returns high.
- Start glitch: `rx` low for 3 ticks then high -> return to IDLE, busy drops, no valid, no error.
- rst asserted mid-DATA after 4 bits of 0xFF -> all outputs 0 the next cycle; following clean frame 0x81 received correctly.
